// File: rtl/field_edit_pkg.sv
// field_edit_pkg: shared state type and field indices for the clock/date edit sequencer
package field_edit_pkg;
  typedef enum logic [1:0] {IDLE, EDIT, HOLD_UP, HOLD_DN} state_t;
  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] F_HOUR = 3'd0;
  localparam logic [SEL_W-1:0] F_MIN  = 3'd1;
  localparam logic [SEL_W-1:0] F_SEC  = 3'd2;
  localparam logic [SEL_W-1:0] F_DAY  = 3'd3;
  localparam logic [SEL_W-1:0] F_MON  = 3'd4;
  localparam logic [SEL_W-1:0] F_YEAR = 3'd5;
endpackage

// File: rtl/hold_repeat_timer.sv
// hold_repeat_timer: loadable down-counter, ticks on the cycle it would reach zero
module hold_repeat_timer #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_run,
  output logic         o_tick
);
  logic [W-1:0] r_cnt;
  // a load wins; otherwise count down while a hold is in progress
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (i_run && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  assign o_tick = i_run && r_cnt == W'(1);
endmodule

// File: rtl/field_edit_ctrl.sv
// field_edit_ctrl: push-button edit sequencer driving enables and up/down strobes for set-point counters
module field_edit_ctrl
  import field_edit_pkg::*;
#(
  parameter int N_FIELDS    = 6,
  parameter int REPEAT_DLY  = 50_000_000,
  parameter int REPEAT_RATE = 10_000_000,
  parameter int TIMEOUT     = 1_000_000_000
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_btn_edit,
  input  logic                i_btn_up,
  input  logic                i_btn_down,
  input  logic                i_btn_left,
  input  logic                i_btn_right,
  output logic [N_FIELDS-1:0] o_en_field,
  output logic                o_aum,
  output logic                o_dism,
  output logic [SEL_W-1:0]    o_sel,
  output logic                o_edit_mode
);
  state_t              r_state;
  logic [4:0]          r_prev;
  logic [N_FIELDS-1:0] r_en;
  logic                r_aum, r_dism, r_edit;
  logic [SEL_W-1:0]    r_sel;
  logic [1:0]          r_pend;
  logic [31:0]         r_to;
  logic [4:0]          w_btn, w_rise;
  logic                w_edit_st, w_up_go, w_dn_go, w_hold_u, w_hold_d, w_strobe;
  logic                w_to_hit, w_exit, w_tick;
  logic [1:0]          w_mv, w_apply;
  logic [SEL_W-1:0]    w_sel_n;

  assign w_btn     = {i_btn_edit, i_btn_up, i_btn_down, i_btn_left, i_btn_right};
  assign w_rise    = w_btn & ~r_prev;
  assign w_edit_st = r_state == EDIT && !w_rise[4];
  assign w_up_go   = w_edit_st && w_rise[3] && !w_rise[2];
  assign w_dn_go   = w_edit_st && w_rise[2] && !w_rise[3];
  assign w_hold_u  = r_state == HOLD_UP && i_btn_up && w_tick && !w_rise[4];
  assign w_hold_d  = r_state == HOLD_DN && i_btn_down && w_tick && !w_rise[4];
  assign w_strobe  = w_up_go || w_dn_go || w_hold_u || w_hold_d;
  assign w_to_hit  = r_state != IDLE && w_rise == '0 && !w_strobe && r_to == 32'(TIMEOUT - 1);
  assign w_exit    = r_state != IDLE && (w_rise[4] || w_to_hit);
  // {next, prev}; a move that coincides with a new press is deferred one cycle so the strobe hits the old field
  assign w_mv      = {w_edit_st && w_rise[0] && !w_rise[1], w_edit_st && w_rise[1] && !w_rise[0]};

  // selection after this cycle's deferred or immediate move, wrapping at both ends
  always_comb begin
    w_apply = r_pend | ((w_up_go || w_dn_go) ? 2'b00 : w_mv);
    w_sel_n = w_apply[1] ? (r_sel == SEL_W'(N_FIELDS - 1) ? '0 : r_sel + 1'b1) :
              w_apply[0] ? (r_sel == '0 ? SEL_W'(N_FIELDS - 1) : r_sel - 1'b1) : r_sel;
  end

  hold_repeat_timer #(.W(32)) u_timer (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_load (w_strobe),
    .i_val  ((w_up_go || w_dn_go) ? 32'(REPEAT_DLY) : 32'(REPEAT_RATE)),
    .i_run  (r_state inside {HOLD_UP, HOLD_DN}),
    .o_tick (w_tick)
  );

  // edit-mode state machine with registered outputs, idle timeout and button history
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_prev  <= '0;
      r_en    <= '0;
      r_aum   <= 1'b0;
      r_dism  <= 1'b0;
      r_edit  <= 1'b0;
      r_sel   <= '0;
      r_pend  <= '0;
      r_to    <= '0;
    end else begin
      r_prev <= w_btn;
      r_aum  <= 1'b0;
      r_dism <= 1'b0;
      r_pend <= '0;
      case (r_state)
        IDLE:
          if (w_rise[4]) begin
            r_state <= EDIT;
            r_sel   <= '0;
            r_en    <= N_FIELDS'(1);
            r_edit  <= 1'b1;
            r_to    <= '0;
          end
        default:
          if (w_exit) begin
            r_state <= IDLE;
            r_en    <= '0;
            r_edit  <= 1'b0;
            r_to    <= '0;
          end else begin
            r_sel  <= w_sel_n;
            r_en   <= N_FIELDS'(1) << w_sel_n;
            r_to   <= (w_rise != '0 || w_strobe) ? '0 : r_to + 32'd1;
            r_aum  <= w_up_go || w_hold_u;
            r_dism <= w_dn_go || w_hold_d;
            r_pend <= (w_up_go || w_dn_go) ? w_mv : 2'b00;
            if (w_up_go) r_state <= HOLD_UP;
            else if (w_dn_go) r_state <= HOLD_DN;
            else if ((r_state == HOLD_UP && !i_btn_up) || (r_state == HOLD_DN && !i_btn_down)) r_state <= EDIT;
          end
      endcase
    end

  assign o_en_field  = r_en;
  assign o_aum       = r_aum;
  assign o_dism      = r_dism;
  assign o_sel       = r_sel;
  assign o_edit_mode = r_edit;
endmodule
